// File: rtl/stein_gcd_pkg.sv
// Shared types and limits for the binary (Stein) GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REDUCE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int GCD_MAX_WIDTH = 32;

endpackage

// File: rtl/stein_gcd.sv
// Iterative binary GCD: strips common factors of two, reduces odd operands by
// halving/subtraction, then restores the common power of two in the result.
module stein_gcd
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero_in
);

    localparam int KW = $clog2(WIDTH + 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] ra_reg, ra_next;
    logic [WIDTH-1:0] rb_reg, rb_next;
    logic [KW-1:0]    k_reg, k_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            ra_reg     <= '0;
            rb_reg     <= '0;
            k_reg      <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ra_reg     <= ra_next;
            rb_reg     <= rb_next;
            k_reg      <= k_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ra_next     = ra_reg;
        rb_next     = rb_reg;
        k_next      = k_reg;
        result_next = result_reg;
        zero_next   = zero_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    ra_next     = a;
                    rb_next     = b;
                    k_next      = '0;
                    result_next = '0;
                    zero_next   = 1'b0;
                    // A zero operand short-circuits: gcd is simply the other one.
                    if (a == '0 || b == '0) begin
                        result_next = a | b;
                        zero_next   = 1'b1;
                        state_next  = FINISH;
                    end else begin
                        state_next  = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (!ra_reg[0] && !rb_reg[0]) begin
                    ra_next = ra_reg >> 1;
                    rb_next = rb_reg >> 1;
                    k_next  = k_reg + 1'b1;
                end else begin
                    state_next = REDUCE;
                end
            end

            REDUCE: begin
                if (!ra_reg[0]) begin
                    ra_next = ra_reg >> 1;
                end else if (!rb_reg[0]) begin
                    rb_next = rb_reg >> 1;
                end else if (ra_reg == rb_reg) begin
                    // ra was shifted right k times, so shifting back cannot overflow.
                    result_next = ra_reg << k_reg;
                    state_next  = FINISH;
                end else if (ra_reg > rb_reg) begin
                    ra_next = ra_reg - rb_reg;
                end else begin
                    rb_next = rb_reg - ra_reg;
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == FINISH);
    assign result  = result_reg;
    assign zero_in = zero_reg;

endmodule

// File: doc/stein_gcd.md
STEIN_GCD -- requirements
Module: stein_gcd

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a computation; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  first operand, unsigned; sampled in the start cycle only.
REQ-006 SHALL have port b  input  WIDTH  second operand, unsigned; sampled in the start cycle only.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-009 SHALL have port result  output  WIDTH  gcd(a,b), held from done until the next accepted start.
REQ-010 SHALL have port zero_in  output  1  high with done when either operand was zero; held with result.

Function
REQ-011 SHALL implement binary (Stein) GCD with states IDLE, SHIFT, REDUCE, FINISH.
REQ-012 IDLE with start=1 SHALL load ra=a, rb=b, k=0 and clear done, result and zero_in; if a==0 or b==0, go to FINISH with final value a|b; else go to SHIFT.
REQ-013 SHIFT SHALL, while ra and rb are both even, right-shift both by 1 and increment k, one step per cycle; else go to REDUCE.
REQ-014 REDUCE SHALL perform one step per cycle, priority: ra even -> ra>>=1; rb even -> rb>>=1; ra==rb -> FINISH with final value ra<<k; ra>rb -> ra=ra-rb; else rb=rb-ra.
REQ-015 FINISH SHALL assert done for exactly one cycle, drive result and zero_in, and return to IDLE on the next edge.
REQ-016 gcd(0,0) SHALL yield result 0 with zero_in=1; gcd(0,x) and gcd(x,0) SHALL yield x with zero_in=1.
REQ-017 k SHALL be $clog2(WIDTH+1) bits wide; ra<<k SHALL never overflow WIDTH bits.
REQ-018 Subtraction SHALL be performed only on the larger operand, with no underflow.
REQ-019 start asserted while busy SHALL be ignored, with no effect on operands or state.
REQ-020 start asserted in the done cycle SHALL be ignored; it is accepted on a later cycle in IDLE.
REQ-021 Latency from the start edge to the done cycle SHALL be at most 4*WIDTH+4 cycles, and exactly 2 cycles for zero operands.
REQ-022 done SHALL be high only in the FINISH state, and busy SHALL be high in that cycle.

Reset
REQ-023 reset=1 SHALL force IDLE, busy=0, done=0, result=0, zero_in=0, ra=rb=0 and k=0 on the next edge.
REQ-024 reset SHALL take precedence over start and over any in-flight computation; no done is produced for an aborted operation.

Structure
REQ-025 Package gcd_pkg SHALL hold typedef state_t (IDLE, SHIFT, REDUCE, FINISH) and constant GCD_MAX_WIDTH=32.
REQ-026 The design SHALL be a single module with one registered FSM plus datapath, with no sub-module.
REQ-027 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Verification (WIDTH=8)
REQ-028 Bench SHALL apply start with a=12, b=18 and check that done occurs once with result=6, zero_in=0, within 36 cycles.
REQ-029 Bench SHALL apply (0,0) and (0,7), and check result=0 then result=7, zero_in=1, with done exactly 2 cycles after start.
REQ-030 Bench SHALL apply (255,1) -> result=1, (128,64) -> result=64 and (200,200) -> result=200, each within 36 cycles.
REQ-031 Bench SHALL sweep all a,b in 1..15 against a reference subtraction GCD, with zero mismatches and a single done per start.
REQ-032 Bench SHALL start (12,18), pulse start with (9,3) at cycle 2, and check that result=6 and the second request is ignored.
REQ-033 Bench SHALL start (255,1), assert reset at cycle 5, and check busy=0, done never high and result=0; a following (12,18) SHALL then yield 6.
